// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM states,
// command width and the command field encodings of the external ALU.
package alu_arb_pkg;

   localparam int CMDW = 4;

   // Command layout is {invertA, invertB, operation[1:0]}
   localparam int CMD_INV_A = 3;
   localparam int CMD_INV_B = 2;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SLT = 2'b11;

   // Full commands; subtraction is an add with B inverted (carry-in from invertB)
   localparam logic [CMDW-1:0] CMD_AND = {1'b0, 1'b0, OP_AND};
   localparam logic [CMDW-1:0] CMD_OR  = {1'b0, 1'b0, OP_OR};
   localparam logic [CMDW-1:0] CMD_ADD = {1'b0, 1'b0, OP_ADD};
   localparam logic [CMDW-1:0] CMD_SUB = {1'b0, 1'b1, OP_ADD};
   localparam logic [CMDW-1:0] CMD_SLT = {1'b0, 1'b1, OP_SLT};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_arb_rr_arb2.sv
// Two-way round-robin grant: one-hot grant from two request bits and a
// priority pointer. Purely combinational; the pointer lives in the caller.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   output logic [1:0] gnt_o
);

   // A lone requester always wins; on contention the pointer decides
   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_arb.sv
// Shares one external ALU between two requesters. A request is accepted
// in IDLE, its operands are presented to the ALU for one EXEC cycle, and
// the captured result is held in RESP until the owner takes it.
module alu_arb
   import alu_arb_pkg::*;
#(
   parameter int W    = 16,
   parameter int CMDW = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_n,
   input  logic [1:0]              req_valid_i,
   output logic [1:0]              req_ready_o,
   input  logic [1:0][W-1:0]       req_a_i,
   input  logic [1:0][W-1:0]       req_b_i,
   input  logic [1:0][CMDW-1:0]    req_cmd_i,
   output logic [1:0]              rsp_valid_o,
   input  logic [1:0]              rsp_ready_i,
   output logic [W-1:0]            rsp_result_o,
   output logic                    rsp_zero_o,
   output logic                    rsp_ovf_o,
   output logic [W-1:0]            alu_src1_o,
   output logic [W-1:0]            alu_src2_o,
   output logic                    alu_inv_a_o,
   output logic                    alu_inv_b_o,
   output logic [1:0]              alu_op_o,
   input  logic [W-1:0]            alu_result_i,
   input  logic                    alu_zero_i,
   input  logic                    alu_ovf_i
);

   state_t          state_q;
   state_t          state_d;
   logic            ptr_q;
   logic [1:0]      gnt;
   logic            accept;
   logic            owner_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [CMDW-1:0] cmd_q;
   logic [W-1:0]    result_q;
   logic            zero_q;
   logic            ovf_q;

   rr_arb2 u_rr_arb2 (
      .req_i (req_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (gnt)
   );

   // Next state and handshakes; grants are blocked while reset is held so
   // nothing can be accepted before the first edge with rst_n high
   always_comb begin
      state_d     = state_q;
      req_ready_o = 2'b00;
      rsp_valid_o = 2'b00;
      accept      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rst_n && (req_valid_i != 2'b00)) begin
               req_ready_o = gnt;
               accept      = 1'b1;
               state_d     = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid_o[owner_q] = 1'b1;
            if (rsp_ready_i[owner_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch the granted request and move the priority pointer past the winner
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         cmd_q   <= '0;
      end else if (accept) begin
         ptr_q   <= ~gnt[1];
         owner_q <= gnt[1];
         a_q     <= req_a_i[gnt[1]];
         b_q     <= req_b_i[gnt[1]];
         cmd_q   <= req_cmd_i[gnt[1]];
      end
   end

   // Capture the ALU outputs on the edge leaving EXEC; held through RESP
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (state_q == ST_EXEC) begin
         result_q <= alu_result_i;
         zero_q   <= alu_zero_i;
         ovf_q    <= alu_ovf_i;
      end
   end

   assign rsp_result_o = result_q;
   assign rsp_zero_o   = zero_q;
   assign rsp_ovf_o    = ovf_q;

   assign alu_src1_o   = a_q;
   assign alu_src2_o   = b_q;
   assign alu_inv_a_o  = cmd_q[CMD_INV_A];
   assign alu_inv_b_o  = cmd_q[CMD_INV_B];
   assign alu_op_o     = cmd_q[1:0];

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb with a behavioural 16-bit ALU on the alu_* ports.
module tb_alu_arb;
   import alu_arb_pkg::*;

   logic             clk;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][15:0] req_a;
   logic [1:0][15:0] req_b;
   logic [1:0][3:0]  req_cmd;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [15:0]      rsp_result;
   logic             rsp_zero;
   logic             rsp_ovf;
   logic [15:0]      alu_src1;
   logic [15:0]      alu_src2;
   logic             alu_inv_a;
   logic             alu_inv_b;
   logic [1:0]       alu_op;
   logic [15:0]      alu_result;
   logic             alu_zero;
   logic             alu_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   alu_arb #(.W(16), .CMDW(4)) dut (
      .clk_i        (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_a_i      (req_a),
      .req_b_i      (req_b),
      .req_cmd_i    (req_cmd),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_result_o (rsp_result),
      .rsp_zero_o   (rsp_zero),
      .rsp_ovf_o    (rsp_ovf),
      .alu_src1_o   (alu_src1),
      .alu_src2_o   (alu_src2),
      .alu_inv_a_o  (alu_inv_a),
      .alu_inv_b_o  (alu_inv_b),
      .alu_op_o     (alu_op),
      .alu_result_i (alu_result),
      .alu_zero_i   (alu_zero),
      .alu_ovf_i    (alu_ovf)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Team ALU model: optional inversions, carry-in from invertB, SLT from sign^overflow
   logic [15:0] m_a;
   logic [15:0] m_b;
   logic [16:0] m_sum;
   logic        m_ovf;
   always_comb begin
      m_a        = alu_inv_a ? ~alu_src1 : alu_src1;
      m_b        = alu_inv_b ? ~alu_src2 : alu_src2;
      m_sum      = {1'b0, m_a} + {1'b0, m_b} + {16'd0, alu_inv_b};
      m_ovf      = (m_a[15] == m_b[15]) && (m_sum[15] != m_a[15]);
      alu_result = 16'h0000;
      alu_ovf    = 1'b0;
      case (alu_op)
         2'b00:   alu_result = m_a & m_b;
         2'b01:   alu_result = m_a | m_b;
         2'b10:   begin alu_result = m_sum[15:0]; alu_ovf = m_ovf; end
         default: begin alu_result = {15'd0, m_sum[15] ^ m_ovf}; alu_ovf = m_ovf; end
      endcase
      alu_zero = (alu_result == 16'h0000);
   end

   // Reset held with both requesters valid: everything stays quiet
   task automatic test_reset();
      rst_n      = 1'b0;
      rsp_ready  = 2'b11;
      req_a[0]   = 16'h7FFF; req_b[0] = 16'h0001; req_cmd[0] = CMD_ADD;
      req_a[1]   = 16'h00FF; req_b[1] = 16'h0F0F; req_cmd[1] = CMD_AND;
      req_valid  = 2'b11;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if ({req_ready, rsp_valid} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL reset_handshake: got %b expected 0000", {req_ready, rsp_valid});
      end
      n_checks++;
      if ({rsp_result, rsp_zero, rsp_ovf} !== 18'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_response: got %h expected 0", {rsp_result, rsp_zero, rsp_ovf});
      end
      n_checks++;
      if ({alu_src1, alu_src2, alu_inv_a, alu_inv_b, alu_op} !== 36'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_alu: got %h expected 0", {alu_src1, alu_src2, alu_inv_a, alu_inv_b, alu_op});
      end
   endtask

   // Both valid out of reset: req0 ADD overflows first, then req1 AND
   task automatic test_both_from_reset();
      @(negedge clk); rst_n = 1'b1; #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL first_grant: got %b expected 01", req_ready);
      end
      @(negedge clk); req_valid = 2'b10; #1;
      n_checks++;
      if ({req_ready, rsp_valid, alu_src1, alu_src2, alu_inv_a, alu_inv_b, alu_op} !==
          {2'b00, 2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 2'b10}) begin
         n_fail++;
         $display("[TB] FAIL exec_req0: got %h expected %h",
                  {req_ready, rsp_valid, alu_src1, alu_src2, alu_inv_a, alu_inv_b, alu_op},
                  {2'b00, 2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 2'b10});
      end
      @(negedge clk); #1;
      n_checks++;
      if ({req_ready, rsp_valid, rsp_result, rsp_zero, rsp_ovf} !== {2'b00, 2'b01, 16'h8000, 1'b0, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL resp_add_ovf: got %h expected %h",
                  {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_ovf}, {2'b00, 2'b01, 16'h8000, 1'b0, 1'b1});
      end
      @(negedge clk); #1;
      n_checks++;
      if (req_ready !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL grant_req1: got %b expected 10", req_ready);
      end
      @(negedge clk); req_valid = 2'b00; #1;
      n_checks++;
      if ({alu_src1, alu_src2, alu_op} !== {16'h00FF, 16'h0F0F, 2'b00}) begin
         n_fail++;
         $display("[TB] FAIL exec_req1: got %h expected %h", {alu_src1, alu_src2, alu_op}, {16'h00FF, 16'h0F0F, 2'b00});
      end
      @(negedge clk); #1;
      n_checks++;
      if ({req_ready, rsp_valid, rsp_result, rsp_zero, rsp_ovf} !== {2'b00, 2'b10, 16'h000F, 1'b0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL resp_and: got %h expected %h",
                  {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_ovf}, {2'b00, 2'b10, 16'h000F, 1'b0, 1'b0});
      end
      @(negedge clk); #1;
      n_checks++;
      if (rsp_valid !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL resp_done: got %b expected 00", rsp_valid);
      end
   endtask

   // Both held valid for six back-to-back transactions: strict alternation
   task automatic test_alternation();
      logic [1:0]  exp_g;
      logic [15:0] exp_r;
      req_a[0] = 16'h1200; req_b[0] = 16'h0034; req_cmd[0] = CMD_OR;
      req_a[1] = 16'h0001; req_b[1] = 16'h0002; req_cmd[1] = CMD_ADD;
      rsp_ready = 2'b11;
      @(negedge clk); req_valid = 2'b11; #1;
      for (int t = 0; t < 6; t++) begin
         exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
         exp_r = (t % 2 == 0) ? 16'h1234 : 16'h0003;
         n_checks++;
         if (req_ready !== exp_g) begin
            n_fail++;
            $display("[TB] FAIL alt_grant%0d: got %b expected %b", t, req_ready, exp_g);
         end
         @(negedge clk); #1;
         @(negedge clk); #1;
         n_checks++;
         if ({rsp_valid, rsp_result} !== {exp_g, exp_r}) begin
            n_fail++;
            $display("[TB] FAIL alt_resp%0d: got %b/%h expected %b/%h", t, rsp_valid, rsp_result, exp_g, exp_r);
         end
         @(negedge clk); #1;
      end
      req_valid = 2'b00;
   endtask

   // Response stalled five cycles with only the other requester's ready high
   task automatic test_back_pressure();
      rsp_ready = 2'b00;
      req_a[1] = 16'h0010; req_b[1] = 16'h0020; req_cmd[1] = CMD_SUB;
      req_a[0] = 16'hFFFF; req_b[0] = 16'h00F0; req_cmd[0] = CMD_AND;
      @(negedge clk); req_valid = 2'b10; #1;
      n_checks++;
      if (req_ready !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL bp_grant: got %b expected 10", req_ready);
      end
      @(negedge clk); req_valid = 2'b01; rsp_ready = 2'b01; #1;
      n_checks++;
      if ({req_ready, rsp_valid} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL bp_exec: got %b expected 0000", {req_ready, rsp_valid});
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if ({req_ready, rsp_valid, rsp_result, rsp_zero, rsp_ovf} !== {2'b00, 2'b10, 16'hFFF0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL bp_hold%0d: got %h expected %h", i,
                     {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_ovf}, {2'b00, 2'b10, 16'hFFF0, 1'b0, 1'b0});
         end
      end
      @(negedge clk); rsp_ready = 2'b11; #1;
      n_checks++;
      if ({req_ready, rsp_valid, rsp_result} !== {2'b00, 2'b10, 16'hFFF0}) begin
         n_fail++;
         $display("[TB] FAIL bp_handshake: got %h expected %h", {req_ready, rsp_valid, rsp_result}, {2'b00, 2'b10, 16'hFFF0});
      end
      @(negedge clk); #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL bp_next_grant: got %b expected 01", req_ready);
      end
      @(negedge clk); req_valid = 2'b00; #1;
      @(negedge clk); #1;
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_zero, rsp_ovf} !== {2'b01, 16'h00F0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL bp_second_resp: got %h expected %h",
                  {rsp_valid, rsp_result, rsp_zero, rsp_ovf}, {2'b01, 16'h00F0, 1'b0, 1'b0});
      end
   endtask

   // Signed compare across the sign boundary, and a subtraction giving zero
   task automatic test_slt_zero();
      @(negedge clk);
      req_a[0] = 16'h8000; req_b[0] = 16'h0001; req_cmd[0] = CMD_SLT;
      req_valid = 2'b01; #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL slt_grant: got %b expected 01", req_ready);
      end
      @(negedge clk); req_valid = 2'b00; #1;
      n_checks++;
      if ({alu_src1, alu_src2, alu_inv_a, alu_inv_b, alu_op} !== {16'h8000, 16'h0001, 1'b0, 1'b1, 2'b11}) begin
         n_fail++;
         $display("[TB] FAIL slt_alu: got %h expected %h",
                  {alu_src1, alu_src2, alu_inv_a, alu_inv_b, alu_op}, {16'h8000, 16'h0001, 1'b0, 1'b1, 2'b11});
      end
      @(negedge clk); #1;
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_zero, rsp_ovf} !== {2'b01, 16'h0001, 1'b0, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL slt_resp: got %h expected %h",
                  {rsp_valid, rsp_result, rsp_zero, rsp_ovf}, {2'b01, 16'h0001, 1'b0, 1'b1});
      end
      @(negedge clk);
      req_a[1] = 16'h1234; req_b[1] = 16'h1234; req_cmd[1] = CMD_SUB;
      req_valid = 2'b10; #1;
      n_checks++;
      if (req_ready !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL sub_grant: got %b expected 10", req_ready);
      end
      @(negedge clk); req_valid = 2'b00; #1;
      @(negedge clk); #1;
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_zero, rsp_ovf} !== {2'b10, 16'h0000, 1'b1, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL sub_zero_resp: got %h expected %h",
                  {rsp_valid, rsp_result, rsp_zero, rsp_ovf}, {2'b10, 16'h0000, 1'b1, 1'b0});
      end
   endtask

   // Reset pulsed during EXEC with the pointer at requester 1
   task automatic test_reset_mid_exec();
      rsp_ready = 2'b11;
      req_a[0] = 16'h0AAA; req_b[0] = 16'h0555; req_cmd[0] = CMD_OR;
      req_a[1] = 16'h0F00; req_b[1] = 16'h00F0; req_cmd[1] = CMD_ADD;
      @(negedge clk); req_valid = 2'b01; #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL pre_reset_grant: got %b expected 01", req_ready);
      end
      @(negedge clk); req_valid = 2'b11; #1;
      n_checks++;
      if (alu_src1 !== 16'h0AAA) begin
         n_fail++;
         $display("[TB] FAIL pre_reset_exec: got %h expected 0aaa", alu_src1);
      end
      rst_n = 1'b0; #1;
      n_checks++;
      if ({req_ready, rsp_valid, rsp_result, rsp_zero, rsp_ovf, alu_src1, alu_src2, alu_inv_a, alu_inv_b, alu_op} !== 58'd0) begin
         n_fail++;
         $display("[TB] FAIL async_reset: got %h expected 0",
                  {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_ovf, alu_src1, alu_src2, alu_inv_a, alu_inv_b, alu_op});
      end
      @(negedge clk); #1;
      n_checks++;
      if ({req_ready, rsp_valid} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL no_resp_in_reset: got %b expected 0000", {req_ready, rsp_valid});
      end
      @(negedge clk); rst_n = 1'b1; #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL grant_after_reset: got %b expected 01", req_ready);
      end
      @(negedge clk); req_valid = 2'b00; #1;
      @(negedge clk); #1;
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_zero, rsp_ovf} !== {2'b01, 16'h0FFF, 1'b0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL resp_after_reset: got %h expected %h",
                  {rsp_valid, rsp_result, rsp_zero, rsp_ovf}, {2'b01, 16'h0FFF, 1'b0, 1'b0});
      end
      @(negedge clk);
   endtask

   // Scenario sequence
   initial begin
      rst_n     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_a     = '0;
      req_b     = '0;
      req_cmd   = '0;
      $display("[TB] starting alu_arb directed tests");
      test_reset();
      test_both_from_reset();
      test_alternation();
      test_back_pressure();
      test_slt_zero();
      test_reset_mid_exec();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Guard against a stuck simulation
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter W, default 16, datapath width of operands and result.
REQ-002 Parameter CMDW, default 4, command width {invertA, invertB, operation[1:0]}.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  2  per-requester request valid (bit n = requester n).
REQ-006 req_ready_o  output  2  per-requester request accepted this cycle.
REQ-007 req_a_i / req_b_i  input  2xW each  per-requester operands A, B.
REQ-008 req_cmd_i  input  2xCMDW  per-requester ALU command.
REQ-009 rsp_valid_o  output  2  per-requester response valid.
REQ-010 rsp_ready_i  input  2  per-requester response accept.
REQ-011 rsp_result_o  output  W  result, shared by both requesters, qualified by rsp_valid_o.
REQ-012 rsp_zero_o / rsp_ovf_o  output  1 each  zero and overflow flags of that result.
REQ-013 alu_src1_o / alu_src2_o  output  W each  operands to the external ALU.
REQ-014 alu_inv_a_o / alu_inv_b_o  output  1 each; alu_op_o  output  2  ALU control.
REQ-015 alu_result_i  input  W; alu_zero_i / alu_ovf_i  input  1 each  combinational ALU outputs.

Function
REQ-016 FSM states IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-017 IDLE: if any req_valid_i bit set, grant one requester, assert its req_ready_o bit for that cycle only, latch its A, B, cmd and the grant index, go EXEC.
REQ-018 req_ready_o SHALL be zero in EXEC and RESP and never have both bits set.
REQ-019 Arbitration round-robin: priority pointer starts at requester 0; when both valid, grant the pointer; after every grant the pointer moves to the other requester.
REQ-020 Single valid requester is granted regardless of pointer; the pointer still moves past it.
REQ-021 EXEC: drive latched operands/controls to the ALU for exactly one cycle, capture alu_result_i, alu_zero_i, alu_ovf_i into response registers on the exiting edge, go RESP.
REQ-022 RESP: assert rsp_valid_o bit of the granted requester only; hold result and flags stable until rsp_ready_i of that bit is high, then go IDLE.
REQ-023 rsp_ready_i of the non-granted requester SHALL be ignored.
REQ-024 Latency: request accepted at edge t gives rsp_valid_o high from t+2; minimum three cycles per transaction (rsp_ready_i held high).
REQ-025 ALU outputs latched operands in all states (no glitching to live request inputs); overflow is reported unmodified for every command.
REQ-026 Requesters SHALL hold req_* stable while valid and not ready; the block does not buffer a second request.

Reset
REQ-027 Reset asserted at any time, including mid-EXEC or RESP, returns FSM to IDLE, drops any in-flight transaction without a response.
REQ-028 Reset values: req_ready_o=0, rsp_valid_o=0, rsp_result_o=0, rsp_zero_o=0, rsp_ovf_o=0, alu_* outputs=0, priority pointer=0.
REQ-029 First grant after reset deassertion occurs no earlier than the first rising edge with rst_n high.

Structure
REQ-030 Shared package holds the FSM state enum, CMDW, and command field encodings (AND=00, OR=01, ADD=10, SLT=11; SUB = ADD with invertB).
REQ-031 One sub-module rr_arb2: two request bits plus pointer in, one-hot grant out, purely combinational.
REQ-032 ALU is external; the bench binds the team's 16-bit ALU to the alu_* ports.

Verification
REQ-033 Req0 only: A=0x0005, B=0x0003, cmd=SUB(0110) -> rsp_valid_o=01 two cycles after accept, result=0x0002, zero=0, ovf=0.
REQ-034 Both valid from reset, req0 ADD 0x7FFF+0x0001, req1 AND 0x00FF&0x0F0F -> req0 first: 0x8000 ovf=1; then req1: 0x000F ovf=0.
REQ-035 Both held valid for 6 transactions -> grants strictly alternate 0,1,0,1,0,1; no request starved.
REQ-036 Back-pressure: rsp_ready_i low 5 cycles in RESP -> result/flags stable, req_ready_o stays 00, no new accept until handshake.
REQ-037 rst_n pulsed low during EXEC -> all outputs zero immediately (asynchronous), no response issued, next grant goes to requester 0.
REQ-038 SLT 0x8000 vs 0x0001 -> result=0x0001; SUB 0x1234-0x1234 -> result=0x0000, zero=1.
